// File: rtl/ex_stage_mc_if.sv
// Bundles the EX stage's upstream inputs and its registered EX/MEM outputs.
// master drives the instruction (upstream); slave is the EX stage itself.
interface ex_stage_mc_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned REG_AW = 5
);
  logic              i_valid;
  logic              i_stall;
  logic              i_flush;
  logic [WIDTH-1:0]  i_data_a;
  logic [WIDTH-1:0]  i_data_b;
  logic [WIDTH-1:0]  i_se;
  logic [REG_AW-1:0] i_rt;
  logic [REG_AW-1:0] i_rd;
  logic [3:0]        i_ex_ctrl;
  logic [1:0]        i_mem_ctrl;
  logic [1:0]        i_wb_ctrl;
  logic [2:0]        i_funct;
  logic              i_mul;

  logic              o_valid;
  logic [WIDTH-1:0]  o_result;
  logic [WIDTH-1:0]  o_data;
  logic [REG_AW-1:0] o_rd;
  logic              o_zero;
  logic [1:0]        o_mem_ctrl;
  logic [1:0]        o_wb_ctrl;
  logic              o_stall;

  modport master (
    output i_valid, i_stall, i_flush, i_data_a, i_data_b, i_se, i_rt, i_rd,
           i_ex_ctrl, i_mem_ctrl, i_wb_ctrl, i_funct, i_mul,
    input  o_valid, o_result, o_data, o_rd, o_zero, o_mem_ctrl, o_wb_ctrl, o_stall
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_data_a, i_data_b, i_se, i_rt, i_rd,
           i_ex_ctrl, i_mem_ctrl, i_wb_ctrl, i_funct, i_mul,
    output o_valid, o_result, o_data, o_rd, o_zero, o_mem_ctrl, o_wb_ctrl, o_stall
  );
endinterface

// File: rtl/ex_stage_mc.sv
// Pipeline EX stage: single-cycle ALU plus an iterative shift-add multiplier
// that stalls upstream while it runs; results land in the EX/MEM output register.
module ex_stage_mc #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned REG_AW = 5,
  parameter bit          MUL_EN = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  ex_stage_mc_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e            r_state;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [WIDTH-1:0]  r_prod;
  logic [WIDTH-1:0]  r_mdata;
  logic [REG_AW-1:0] r_mrd;
  logic [1:0]        r_mmem;
  logic [1:0]        r_mwb;

  logic              r_valid;
  logic [WIDTH-1:0]  r_result;
  logic [WIDTH-1:0]  r_data;
  logic [REG_AW-1:0] r_rd;
  logic              r_zero;
  logic [1:0]        r_mem;
  logic [1:0]        r_wb;

  logic [WIDTH-1:0]  w_opb;
  logic [WIDTH-1:0]  w_alu;
  logic [REG_AW-1:0] w_rd;
  logic              w_accept;
  logic              w_mul_req;
  logic [WIDTH-1:0]  w_prod_next;
  logic              w_cnt_full;
  logic              w_cnt_last;
  logic [WIDTH-1:0]  w_mul_res;
  logic              w_mul_done;

  assign w_opb     = bus.i_ex_ctrl[3] ? bus.i_se : bus.i_data_b;
  assign w_rd      = bus.i_ex_ctrl[0] ? bus.i_rd : bus.i_rt;
  assign w_accept  = bus.i_valid & (r_state == StIdle) & ~bus.i_stall & ~bus.i_flush;
  assign w_mul_req = MUL_EN & bus.i_mul;

  always_comb begin
    w_alu = '0;
    case (bus.i_ex_ctrl[2:1])
      2'b00: w_alu = bus.i_data_a + w_opb;
      2'b01: w_alu = bus.i_data_a - w_opb;
      2'b11: w_alu = bus.i_data_a | w_opb;
      default: begin
        case (bus.i_funct)
          3'b000:  w_alu = bus.i_data_a & w_opb;
          3'b001:  w_alu = bus.i_data_a | w_opb;
          3'b010:  w_alu = bus.i_data_a + w_opb;
          3'b110:  w_alu = bus.i_data_a - w_opb;
          3'b111:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.i_data_a) < $signed(w_opb))};
          default: w_alu = '0;
        endcase
      end
    endcase
  end

  // One shift-add step; once the count saturates the product is final and held.
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_cnt_full  = (r_cnt == CW'(WIDTH));
  assign w_cnt_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_mul_res   = w_cnt_full ? r_prod : w_prod_next;
  assign w_mul_done  = (r_state == StMul) & ~bus.i_stall & (w_cnt_full | w_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_mdata  <= '0;
      r_mrd    <= '0;
      r_mmem   <= '0;
      r_mwb    <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_data   <= '0;
      r_rd     <= '0;
      r_zero   <= 1'b0;
      r_mem    <= '0;
      r_wb     <= '0;
    end else if (bus.i_flush) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_mem   <= '0;
      r_wb    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept && w_mul_req) begin
            r_state  <= StMul;
            r_cnt    <= '0;
            r_mcand  <= bus.i_data_a;
            r_mplier <= w_opb;
            r_prod   <= '0;
            r_mdata  <= bus.i_data_b;
            r_mrd    <= w_rd;
            r_mmem   <= bus.i_mem_ctrl;
            r_mwb    <= bus.i_wb_ctrl;
            r_valid  <= 1'b0;
            r_mem    <= '0;
            r_wb     <= '0;
          end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= w_alu;
            r_data   <= bus.i_data_b;
            r_rd     <= w_rd;
            r_zero   <= (w_alu == '0);
            r_mem    <= bus.i_mem_ctrl;
            r_wb     <= bus.i_wb_ctrl;
          end else if (!bus.i_stall) begin
            r_valid <= 1'b0;
            r_mem   <= '0;
            r_wb    <= '0;
          end
        end
        StMul: begin
          if (!w_cnt_full) begin
            r_prod   <= w_prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
          end
          if (w_mul_done) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_valid  <= 1'b1;
            r_result <= w_mul_res;
            r_data   <= r_mdata;
            r_rd     <= r_mrd;
            r_zero   <= (w_mul_res == '0);
            r_mem    <= r_mmem;
            r_wb     <= r_mwb;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.o_valid    = r_valid;
  assign bus.o_result   = r_result;
  assign bus.o_data     = r_data;
  assign bus.o_rd       = r_rd;
  assign bus.o_zero     = r_zero;
  assign bus.o_mem_ctrl = r_mem;
  assign bus.o_wb_ctrl  = r_wb;
  assign bus.o_stall    = (r_state == StMul);
endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed plus randomized bench for ex_stage_mc, checked against a
// behavioural ALU/multiply model with immediate assertions.
module tb_ex_stage_mc;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ex_stage_mc_if #(.WIDTH(32), .REG_AW(5)) bus ();

  ex_stage_mc #(.WIDTH(32), .REG_AW(5), .MUL_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] se,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [3:0] exc,
                       input logic [1:0] mem, input logic [1:0] wb, input logic [2:0] f,
                       input logic mul, input logic valid);
    bus.i_data_a   = a;
    bus.i_data_b   = b;
    bus.i_se       = se;
    bus.i_rt       = rt;
    bus.i_rd       = rd;
    bus.i_ex_ctrl  = exc;
    bus.i_mem_ctrl = mem;
    bus.i_wb_ctrl  = wb;
    bus.i_funct    = f;
    bus.i_mul      = mul;
    bus.i_valid    = valid;
  endtask

  // Reference ALU straight from the opcode table.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] se, input logic [3:0] exc,
                                          input logic [2:0] f);
    logic [31:0] op;
    int          alu_op;
    op     = exc[3] ? se : b;
    alu_op = int'(exc[2:1]);
    if (alu_op == 0) return a + op;
    if (alu_op == 1) return a - op;
    if (alu_op == 3) return a | op;
    if (f == 3'd0) return a & op;
    if (f == 3'd1) return a | op;
    if (f == 3'd2) return a + op;
    if (f == 3'd6) return a - op;
    if (f == 3'd7) return ($signed(a) < $signed(op)) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  task automatic expect_load(input string tag, input logic [31:0] res, input logic [31:0] data,
                             input logic [4:0] rd, input logic [1:0] mem, input logic [1:0] wb);
    chk({tag, ".valid"}, 32'(bus.o_valid), 32'd1);
    chk({tag, ".result"}, bus.o_result, res);
    chk({tag, ".data"}, bus.o_data, data);
    chk({tag, ".rd"}, 32'(bus.o_rd), 32'(rd));
    chk({tag, ".zero"}, 32'(bus.o_zero), (res == 32'd0) ? 32'd1 : 32'd0);
    chk({tag, ".mem"}, 32'(bus.o_mem_ctrl), 32'(mem));
    chk({tag, ".wb"}, 32'(bus.o_wb_ctrl), 32'(wb));
  endtask

  task automatic expect_bubble(input string tag);
    chk({tag, ".valid"}, 32'(bus.o_valid), 32'd0);
    chk({tag, ".mem"}, 32'(bus.o_mem_ctrl), 32'd0);
    chk({tag, ".wb"}, 32'(bus.o_wb_ctrl), 32'd0);
  endtask

  // Issue a multiply and wait (bounded) for its result.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [1:0] wb);
    int edges;
    int stall_cycles;
    drive(a, b, 32'd0, 5'd0, rd, 4'b0101, 2'b00, wb, 3'd2, 1'b1, 1'b1);
    tick();
    drive(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 4'b0000, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0);
    chk({tag, ".stall_on"}, 32'(bus.o_stall), 32'd1);
    expect_bubble({tag, ".accept"});
    edges        = 0;
    stall_cycles = 0;
    while (!bus.o_valid && edges < 40) begin
      if (bus.o_stall) stall_cycles++;
      tick();
      edges++;
    end
    chk({tag, ".latency"}, 32'(edges), 32'd32);
    chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'd32);
    chk({tag, ".stall_off"}, 32'(bus.o_stall), 32'd0);
    expect_load(tag, a * b, b, rd, 2'b00, wb);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] se;
    logic [31:0] exp_res;
    logic [3:0]  exc;
    logic [2:0]  f;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  mem;
    logic [1:0]  wb;
    logic        valid;
    logic        flush;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.i_stall = 1'b0;
    bus.i_flush = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 4'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);

    // Reset state.
    tick();
    chk("rst.valid", 32'(bus.o_valid), 32'd0);
    chk("rst.result", bus.o_result, 32'd0);
    chk("rst.stall", 32'(bus.o_stall), 32'd0);
    chk("rst.wb", 32'(bus.o_wb_ctrl), 32'd0);
    #2 rst_n = 1'b1;

    // Immediate-operand ADD via funct decode.
    drive(32'd4, 32'd8, 32'hFFFF_FFFF, 5'd8, 5'd9, 4'b1101, 2'b00, 2'b11, 3'b010, 1'b0, 1'b1);
    exp_res = ref_alu(32'd4, 32'd8, 32'hFFFF_FFFF, 4'b1101, 3'b010);
    tick();
    chk("add.const", bus.o_result, 32'd3);
    expect_load("add", exp_res, 32'd8, 5'd9, 2'b00, 2'b11);

    // Downstream stall holds the output register and blocks acceptance.
    bus.i_stall = 1'b1;
    drive(32'd100, 32'd200, 32'd0, 5'd1, 5'd2, 4'b0000, 2'b01, 2'b10, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_load("stall_hold", 32'd3, 32'd8, 5'd9, 2'b00, 2'b11);
    end
    bus.i_stall = 1'b0;
    bus.i_valid = 1'b0;
    tick();
    expect_bubble("stall_release");

    // Signed SLT both ways round.
    drive(32'hFFFF_FFFF, 32'd1, 32'd0, 5'd3, 5'd4, 4'b0100, 2'b10, 2'b01, 3'b111, 1'b0, 1'b1);
    tick();
    expect_load("slt_neg", 32'd1, 32'd1, 5'd3, 2'b10, 2'b01);
    drive(32'd1, 32'hFFFF_FFFF, 32'd0, 5'd3, 5'd4, 4'b0100, 2'b10, 2'b01, 3'b111, 1'b0, 1'b1);
    tick();
    expect_load("slt_pos", 32'd0, 32'hFFFF_FFFF, 5'd3, 2'b10, 2'b01);

    // Flush beats both stall and a valid instruction.
    bus.i_stall = 1'b1;
    bus.i_flush = 1'b1;
    tick();
    expect_bubble("flush_over_stall");
    bus.i_stall = 1'b0;
    bus.i_flush = 1'b0;

    // Random single-cycle operations.
    for (int i = 0; i < 40; i++) begin
      a     = $urandom;
      b     = ($urandom_range(0, 3) == 0) ? a : $urandom;
      se    = ($urandom_range(0, 1) == 0) ? a : $urandom;
      exc   = 4'($urandom_range(0, 15));
      f     = 3'($urandom_range(0, 7));
      rt    = 5'($urandom_range(0, 31));
      rd    = 5'($urandom_range(0, 31));
      mem   = 2'($urandom_range(0, 3));
      wb    = 2'($urandom_range(0, 3));
      valid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      drive(a, b, se, rt, rd, exc, mem, wb, f, 1'b0, valid);
      bus.i_flush = flush;
      tick();
      if (valid && !flush)
        expect_load("rand_alu", ref_alu(a, b, se, exc, f), b, exc[0] ? rd : rt, mem, wb);
      else
        expect_bubble("rand_idle");
    end
    bus.i_flush = 1'b0;

    // Multiply: directed then random operands.
    run_mul("mul_7x13", 32'd7, 32'd13, 5'd17, 2'b01);
    chk("mul_7x13.const", bus.o_result, 32'd91);
    for (int i = 0; i < 3; i++) begin
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(0, 31));
      run_mul("mul_rand", a, b, rd, 2'b11);
    end

    // Flush aborts a multiply at its tenth edge.
    drive(32'd9, 32'd9, 32'd0, 5'd0, 5'd5, 4'b0101, 2'b00, 2'b01, 3'd2, 1'b1, 1'b1);
    tick();
    bus.i_valid = 1'b0;
    bus.i_mul   = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("flush_mul.busy", 32'(bus.o_stall), 32'd1);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("flush_mul.stall", 32'(bus.o_stall), 32'd0);
    expect_bubble("flush_mul");
    drive(32'd20, 32'd22, 32'd0, 5'd6, 5'd7, 4'b0000, 2'b01, 2'b10, 3'd0, 1'b0, 1'b1);
    tick();
    expect_load("after_flush", 32'd42, 32'd22, 5'd6, 2'b01, 2'b10);

    // Multiply completes while downstream is stalled.
    drive(32'd5, 32'd6, 32'd0, 5'd0, 5'd12, 4'b0101, 2'b00, 2'b01, 3'd2, 1'b1, 1'b1);
    tick();
    bus.i_valid = 1'b0;
    bus.i_mul   = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    bus.i_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mul_stall.valid", 32'(bus.o_valid), 32'd0);
      chk("mul_stall.busy", 32'(bus.o_stall), 32'd1);
    end
    bus.i_stall = 1'b0;
    tick();
    expect_load("mul_stall", 32'd30, 32'd6, 5'd12, 2'b00, 2'b01);

    // Asynchronous reset between edges mid-multiply.
    drive(32'd3, 32'd3, 32'd0, 5'd0, 5'd1, 4'b0101, 2'b00, 2'b01, 3'd2, 1'b1, 1'b1);
    tick();
    bus.i_valid = 1'b0;
    bus.i_mul   = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(bus.o_valid), 32'd0);
    chk("arst.result", bus.o_result, 32'd0);
    chk("arst.data", bus.o_data, 32'd0);
    chk("arst.rd", 32'(bus.o_rd), 32'd0);
    chk("arst.zero", 32'(bus.o_zero), 32'd0);
    chk("arst.mem", 32'(bus.o_mem_ctrl), 32'd0);
    chk("arst.wb", 32'(bus.o_wb_ctrl), 32'd0);
    chk("arst.stall", 32'(bus.o_stall), 32'd0);
    #1 rst_n = 1'b1;
    drive(32'd50, 32'd8, 32'd0, 5'd2, 5'd3, 4'b0010, 2'b00, 2'b01, 3'd0, 1'b0, 1'b1);
    tick();
    expect_load("post_rst", 32'd42, 32'd8, 5'd2, 2'b00, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_stage_mc.md
EX_STAGE_MC -- requirements
Module: ex_stage_mc

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (>=8).
REQ-002 Parameter REG_AW, default 5, register-specifier width.
REQ-003 Parameter MUL_EN, default 1: 1 enables the iterative multiplier; 0 treats In_Mul as 0.
REQ-004 Clk  in  1  single clock; all state updates on rising edge.
REQ-005 Rst_n  in  1  reset, asynchronous, active-low.
REQ-006 In_Valid  in  1  upstream presents a valid instruction.
REQ-007 In_Stall  in  1  MEM stage cannot accept; hold output register.
REQ-008 In_Flush  in  1  synchronous squash of EX contents.
REQ-009 In_DataA, In_DataB, In_SE  in  WIDTH each  operand A, operand B, sign-extended immediate.
REQ-010 In_Rt, In_Rd  in  REG_AW each  destination candidates.
REQ-011 In_EXControl  in  4  [3] ALUSrc, [2:1] ALUOp, [0] RegDst.
REQ-012 In_MEMControl  in  2  [1] MemWrite, [0] MemRead; In_WBControl  in  2  [1] MemToReg, [0] RegWrite.
REQ-013 In_Funct  in  3  ALU control code; In_Mul  in  1  select multi-cycle multiply.
REQ-014 Out_Valid  out  1; Out_Result  out  WIDTH; Out_Data  out  WIDTH; Out_Rd  out  REG_AW; Out_Zero  out  1.
REQ-015 Out_MEMControl  out  2; Out_WBControl  out  2; Out_Stall  out  1  upstream must hold inputs.

Function
REQ-016 Operand B' = ALUSrc ? In_SE : In_DataB.
REQ-017 ALUOp 00 -> ADD; 01 -> SUB; 11 -> OR; 10 -> decode In_Funct: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed, result 1 or 0), other codes -> 0.
REQ-018 Arithmetic modulo 2^WIDTH; no overflow flag or trap.
REQ-019 Accept = In_Valid & ~Out_Stall & ~In_Stall & ~In_Flush.
REQ-020 Non-multiply accept: on that edge output register loads Result, Data=In_DataB, Rd=RegDst?In_Rd:In_Rt, MEM/WB controls, Zero=(Result==0), Out_Valid=1; latency 1 edge.
REQ-021 Edge with no accept, no In_Stall, state IDLE: Out_Valid=0 and Out_MEMControl/Out_WBControl=0 (bubble); other outputs don't-care.
REQ-022 In_Stall=1: all output registers hold, no accept.
REQ-023 FSM states IDLE, MUL; reset state IDLE.
REQ-024 IDLE->MUL on accept with In_Mul=1 (MUL_EN=1): capture A, B', Rd/controls, clear product, count=0; output register loads bubble that edge unless In_Stall.
REQ-025 MUL: one shift-add iteration per edge; after WIDTH iterations product low WIDTH bits ready.
REQ-026 On the WIDTH-th MUL edge with In_Stall=0: output register loads product as Out_Result (Out_Data=captured B), Out_Valid=1, state->IDLE; Out_Valid rises WIDTH edges after accept edge.
REQ-027 Iterations complete but In_Stall=1: remain MUL, count saturated, product held, load on first edge with In_Stall=0.
REQ-028 Out_Stall = (state==MUL), combinational; no accept while MUL.
REQ-029 In_Flush=1 at an edge: state->IDLE, multiply aborted, Out_Valid=0, Out_MEMControl/Out_WBControl=0; flush overrides In_Stall and accept.

Reset
REQ-030 Rst_n low: immediately, independent of Clk, state=IDLE, count=0, Out_Valid=0, Out_Result=0, Out_Data=0, Out_Rd=0, Out_Zero=0, Out_MEMControl=0, Out_WBControl=0, Out_Stall=0.
REQ-031 Reset mid-multiply discards the operation; first edge after release may accept.

Verification
REQ-032 A=4, B=8, SE=0xFFFFFFFF, Rt=8, Rd=9, EXControl=1101, MEM=00, WB=11, Funct=010, Valid=1 -> next edge Result=3, Data=8, Rd=9, WB=11, MEM=00, Valid=1, Zero=0.
REQ-033 A=0xFFFFFFFF, B=1, EXControl=0100, Funct=111 -> Result=1; swap A/B -> Result=0, Zero=1.
REQ-034 A=7, B=13, In_Mul=1, EXControl=0101 -> Out_Stall high 32 cycles, Result=91, Valid=1 at edge 32 after accept.
REQ-035 Multiply accepted, In_Flush pulsed at edge 10 -> Out_Stall=0 after edge, Valid=0, MEM/WB=00, next instruction accepted.
REQ-036 In_Stall held 3 cycles after ADD result -> outputs unchanged; multiply completing under In_Stall loads only after release.
REQ-037 Rst_n low mid-multiply between edges -> all outputs 0 and Out_Stall=0 immediately.
